// File: rtl/if_stage_pipe_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pipe_pkg
// Shared definitions for the fetch stage: next-PC select encodings, default
// reset PC, the bubble instruction word and a word-alignment helper.
// ----------------------------------------------------------------------------
package if_stage_pipe_pkg;

  // Next-PC select encodings driven by the ID stage
  typedef enum logic [1:0] {
    PCSRC_PC4 = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JMP = 2'b10,
    PCSRC_JR  = 2'b11
  } pcsrc_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;  // sll $0,$0,0

  // Instruction fetch is word addressed; drop the byte offset
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pipe_pc_next_mux.sv
// ----------------------------------------------------------------------------
// pc_next_mux
// Combinational 4:1 next-PC select with the byte offset cleared.
// Ports:
//   pcsrc  in  2   select: pc+4 / branch / jump / jr
//   pc4    in  32  sequential successor of pc
//   bpc    in  32  branch target
//   jpc    in  32  j/jal target
//   rpc    in  32  jr target (register value, may be unaligned)
//   npc    out 32  selected next PC, bits [1:0] forced to zero
// ----------------------------------------------------------------------------
module pc_next_mux
  import if_stage_pipe_pkg::*;
(
  input  logic [1:0]  pcsrc,
  input  logic [31:0] pc4,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  output logic [31:0] npc
);

  logic [31:0] sel_s;

  // Target select followed by alignment
  always_comb begin
    sel_s = pc4;
    case (pcsrc_e'(pcsrc))
      PCSRC_PC4: sel_s = pc4;
      PCSRC_BR:  sel_s = bpc;
      PCSRC_JMP: sel_s = jpc;
      PCSRC_JR:  sel_s = rpc;
      default:   sel_s = pc4;
    endcase
    npc = word_align(sel_s);
  end

endmodule

// File: rtl/if_stage_pipe.sv
// ----------------------------------------------------------------------------
// if_stage_pipe
// Fetch stage plus IF/ID pipeline register of the 5-stage MIPS-subset core.
// Holds the PC, selects the next PC, drives the instruction-memory address and
// latches the fetched word into IF/ID. Flush inserts a bubble, stall holds
// everything. Saturating counters record stall and flush cycles.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   stall        load-use hazard: hold PC and IF/ID
//   flush        squash IF/ID next edge and redirect
//   pcsrc        next-PC select (00 pc+4, 01 bpc, 10 jpc, 11 rpc)
//   bpc/jpc/rpc  redirect targets from ID
//   imem_rdata   instruction word at imem_addr (same cycle)
//   imem_addr    = pc
//   pc           current fetch PC
//   id_inst      IF/ID instruction
//   id_pc4       IF/ID pc+4
//   id_valid     1 = real instruction, 0 = bubble
//   stall_cnt    saturating count of stall cycles
//   flush_cnt    saturating count of flush cycles not masked by a stall
// ----------------------------------------------------------------------------
module if_stage_pipe
  import if_stage_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       pcsrc,
  input  logic [31:0]      bpc,
  input  logic [31:0]      jpc,
  input  logic [31:0]      rpc,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] pc4_s;
  logic [31:0] npc_s;

  // Sequential successor; wraps naturally modulo 2^32
  always_comb begin
    pc4_s     = pc + 32'd4;
    imem_addr = pc;
  end

  pc_next_mux u_pc_next_mux (
    .pcsrc (pcsrc),
    .pc4   (pc4_s),
    .bpc   (bpc),
    .jpc   (jpc),
    .rpc   (rpc),
    .npc   (npc_s)
  );

  // PC, IF/ID register and event counters; rst > stall > flush > normal
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      id_inst   <= NOP_INST;
      id_pc4    <= 32'h0000_0000;
      id_valid  <= 1'b0;
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else if (stall) begin
      // Flush and pcsrc are ignored: the ID branch is re-evaluated after the stall
      if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end else if (flush) begin
      pc       <= npc_s;
      id_inst  <= NOP_INST;
      id_pc4   <= 32'h0000_0000;
      id_valid <= 1'b0;
      if (flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end else begin
      pc       <= npc_s;
      id_inst  <= imem_rdata;
      id_pc4   <= pc4_s;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage_pipe.sv
// ----------------------------------------------------------------------------
// tb_if_stage_pipe
// Directed bench for if_stage_pipe. A reference model computes expected state
// whenever stimulus is driven and pushes it to a scoreboard queue; the entry
// is popped and compared after the clock edge. A second instance with a 4-bit
// counter width shares the stimulus to exercise counter saturation.
// ----------------------------------------------------------------------------
module tb_if_stage_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    logic [3:0]  scnt4;
    logic [3:0]  fcnt4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, jpc, rpc;
  logic [31:0] imem_rdata, imem_addr, pc, id_inst, id_pc4;
  logic        id_valid;
  logic [15:0] stall_cnt, flush_cnt;
  logic [31:0] imem_rdata4, imem_addr4, pc_4, id_inst_4, id_pc4_4;
  logic        id_valid_4;
  logic [3:0]  stall_cnt_4, flush_cnt_4;

  int errors = 0;
  int checks = 0;
  exp_t sb_q[$];

  // model state
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid;
  logic [15:0] m_scnt, m_fcnt;
  logic [3:0]  m_scnt4, m_fcnt4;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_0004: return 32'h2002_0007;
      32'h0000_0008: return 32'h2003_0009;
      32'h0000_0040: return 32'h2004_0040;
      default:       return {16'hDEAD, a[15:0]};
    endcase
  endfunction

  always_comb imem_rdata  = rom_f(imem_addr);
  always_comb imem_rdata4 = rom_f(imem_addr4);

  if_stage_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pcsrc(pcsrc),
    .bpc(bpc), .jpc(jpc), .rpc(rpc), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .pc(pc), .id_inst(id_inst), .id_pc4(id_pc4),
    .id_valid(id_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_stage_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pcsrc(pcsrc),
    .bpc(bpc), .jpc(jpc), .rpc(rpc), .imem_rdata(imem_rdata4),
    .imem_addr(imem_addr4), .pc(pc_4), .id_inst(id_inst_4), .id_pc4(id_pc4_4),
    .id_valid(id_valid_4), .stall_cnt(stall_cnt_4), .flush_cnt(flush_cnt_4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, predict, push, clock, pop, compare
  task automatic step(input logic r, input logic s, input logic f,
                      input logic [1:0] src, input logic [31:0] tgt);
    logic [31:0] n;
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; stall = s; flush = f; pcsrc = src;
    bpc = 32'h1111_1110; jpc = 32'h2222_2220; rpc = 32'h3333_3330;
    case (src)
      2'b01:   bpc = tgt;
      2'b10:   jpc = tgt;
      2'b11:   rpc = tgt;
      default: ;
    endcase
    case (src)
      2'b00:   n = m_pc + 32'd4;
      2'b01:   n = bpc;
      2'b10:   n = jpc;
      default: n = rpc;
    endcase
    n[1:0] = 2'b00;
    if (r) begin
      m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_scnt = 16'h0; m_fcnt = 16'h0; m_scnt4 = 4'h0; m_fcnt4 = 4'h0;
    end else if (s) begin
      if (m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
      if (m_scnt4 != 4'hF) m_scnt4 = m_scnt4 + 4'd1;
    end else if (f) begin
      m_pc = n; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
      if (m_fcnt4 != 4'hF) m_fcnt4 = m_fcnt4 + 4'd1;
    end else begin
      m_inst = rom_f(m_pc); m_pc4 = m_pc + 32'd4; m_pc = n; m_valid = 1'b1;
    end
    e = '{pc: m_pc, inst: m_inst, pc4: m_pc4, valid: m_valid,
          scnt: m_scnt, fcnt: m_fcnt, scnt4: m_scnt4, fcnt4: m_fcnt4};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      chk("pc",        pc,                   got.pc);
      chk("imem_addr", imem_addr,            got.pc);
      chk("id_inst",   id_inst,              got.inst);
      chk("id_pc4",    id_pc4,               got.pc4);
      chk("id_valid",  {31'h0, id_valid},    {31'h0, got.valid});
      chk("stall_cnt", {16'h0, stall_cnt},   {16'h0, got.scnt});
      chk("flush_cnt", {16'h0, flush_cnt},   {16'h0, got.fcnt});
      chk("stall_cnt4", {28'h0, stall_cnt_4}, {28'h0, got.scnt4});
      chk("flush_cnt4", {28'h0, flush_cnt_4}, {28'h0, got.fcnt4});
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pcsrc = 2'b00;
    bpc = 32'h0; jpc = 32'h0; rpc = 32'h0;
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_scnt = 16'h0; m_fcnt = 16'h0; m_scnt4 = 4'h0; m_fcnt4 = 4'h0;

    // 1: reset two cycles (second one with stall/flush to show rst wins)
    step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    step(1'b1, 1'b1, 1'b1, 2'b10, 32'h80);
    chk("t1_pc0", pc, 32'h0);
    chk("t1_valid0", {31'h0, id_valid}, 32'h0);

    // 2: sequential fetch
    step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    chk("t2_inst1", id_inst, 32'h2001_0005);
    chk("t2_pc4_1", id_pc4, 32'h4);
    step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    chk("t2_inst2", id_inst, 32'h2002_0007);
    chk("t2_pc", pc, 32'h8);

    // 3: jump at pc=8 -> one bubble then target word
    step(1'b0, 1'b0, 1'b1, 2'b10, 32'h40);
    chk("t3_pc", pc, 32'h40);
    chk("t3_fcnt", {16'h0, flush_cnt}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    chk("t3_inst", id_inst, 32'h2004_0040);

    // 4: redirect to 12, then stall three cycles with a flush attempt inside
    step(1'b0, 1'b0, 1'b1, 2'b10, 32'hC);
    step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    step(1'b0, 1'b0, 1'b1, 2'b10, 32'hC);
    step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
    step(1'b0, 1'b1, 1'b1, 2'b10, 32'h80);
    step(1'b0, 1'b1, 1'b0, 2'b01, 32'h90);
    chk("t4_pc", pc, 32'hC);
    chk("t4_scnt", {16'h0, stall_cnt}, 32'h3);
    chk("t4_fcnt", {16'h0, flush_cnt}, 32'h3);
    step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    chk("t4_resume", id_inst, 32'hDEAD_000C);

    // 5: jr with unaligned target, branch, and pc wrap
    step(1'b0, 1'b0, 1'b1, 2'b11, 32'h0000_0103);
    chk("t5_jr", pc, 32'h100);
    step(1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0022);
    chk("t5_br", pc, 32'h20);
    step(1'b0, 1'b0, 1'b1, 2'b10, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    chk("t5_wrap", pc, 32'h0);
    chk("t5_wrap_pc4", id_pc4, 32'h0);

    // 6: long stall saturates the 4-bit counter, then reset mid-stall
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
    chk("t6_sat4", {28'h0, stall_cnt_4}, 32'hF);
    step(1'b1, 1'b1, 1'b1, 2'b11, 32'h200);
    chk("t6_rst_pc", pc, 32'h0);
    chk("t6_rst_cnt4", {28'h0, stall_cnt_4}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    chk("t6_after", id_inst, 32'h2002_0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
